// File: rtl/cache_types_pkg.sv
// Shared cache types: way index, way count and the allocation sequencer states.
package cache_types_pkg;

  localparam int unsigned NUM_WAYS = 8;

  typedef logic [2:0] way_t;

  typedef enum logic [2:0] {
    IDLE,
    VICTIM,
    WB,
    FILL,
    UPDATE
  } alloc_state_e;

endpackage

// File: rtl/plru.sv
// 8-way tree pseudo-LRU for one set. Node bit = 1 means the victim lies in the lower half.
module plru
  import cache_types_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  way_t mru,
  output way_t victim_c
);

  // tree[0] root, tree[1..2] quarter nodes, tree[3..6] pair nodes
  logic [6:0] tree_q;
  logic [6:0] tree_n;

  // Point every node on the MRU path away from the MRU way
  always_comb begin
    tree_n = tree_q;
    if (load) begin
      tree_n[0] = mru[2];
      if (mru[2]) tree_n[2] = mru[1];
      else        tree_n[1] = mru[1];
      case (mru[2:1])
        2'd0:    tree_n[3] = mru[0];
        2'd1:    tree_n[4] = mru[0];
        2'd2:    tree_n[5] = mru[0];
        default: tree_n[6] = mru[0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tree_q <= '1;
    else     tree_q <= tree_n;
  end

  always_comb begin
    victim_c    = '0;
    victim_c[2] = ~tree_q[0];
    victim_c[1] = victim_c[2] ? ~tree_q[2] : ~tree_q[1];
    case (victim_c[2:1])
      2'd0:    victim_c[0] = ~tree_q[3];
      2'd1:    victim_c[0] = ~tree_q[4];
      2'd2:    victim_c[0] = ~tree_q[5];
      default: victim_c[0] = ~tree_q[6];
    endcase
  end

endmodule

// File: rtl/way_alloc_ctrl.sv
// Way allocation sequencer: picks hit / lowest invalid / PLRU victim way,
// runs writeback and fill handshakes, then marks the way MRU in its set.
module way_alloc_ctrl
  import cache_types_pkg::*;
#(
  parameter int unsigned S_INDEX  = 3,
  parameter int unsigned NUM_WAYS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [S_INDEX-1:0] req_index,
  input  logic               req_hit,
  input  logic [2:0]         req_hit_way,
  input  logic [7:0]         req_valid_vec,
  input  logic [7:0]         req_dirty_vec,
  output logic               wb_req,
  output logic [2:0]         wb_way,
  input  logic               wb_ack,
  output logic               fill_req,
  output logic [2:0]         fill_way,
  input  logic               fill_ack,
  output logic               done,
  output logic [2:0]         done_way,
  output logic               done_miss
);

  localparam int unsigned NUM_SETS = 1 << S_INDEX;

  if (NUM_WAYS != 8) begin : g_bad_ways
    $error("way_alloc_ctrl supports only NUM_WAYS = 8");
  end

  alloc_state_e       state, state_n;
  logic [S_INDEX-1:0] idx_q, idx_n;
  logic               hit_q, hit_n;
  logic [7:0]         vvec_q, vvec_n;
  logic [7:0]         dvec_q, dvec_n;
  way_t               way_q, way_n;
  way_t               victim_c [NUM_SETS];

  function automatic way_t first_invalid(input logic [7:0] v);
    way_t w;
    w = '0;
    for (int i = 7; i >= 0; i--) begin
      if (!v[i]) w = 3'(i);
    end
    return w;
  endfunction

  for (genvar g = 0; g < NUM_SETS; g++) begin : g_set
    plru u_plru (
      .clk      (clk),
      .rst      (rst),
      .load     ((state == UPDATE) && (idx_q == S_INDEX'(g))),
      .mru      (way_q),
      .victim_c (victim_c[g])
    );
  end

  // Next-state and request latching
  always_comb begin
    state_n = state;
    idx_n   = idx_q;
    hit_n   = hit_q;
    vvec_n  = vvec_q;
    dvec_n  = dvec_q;
    way_n   = way_q;
    case (state)
      IDLE: begin
        if (req_valid) begin
          idx_n  = req_index;
          hit_n  = req_hit;
          vvec_n = req_valid_vec;
          dvec_n = req_dirty_vec;
          if (req_hit) begin
            way_n   = req_hit_way;
            state_n = UPDATE;
          end else begin
            state_n = VICTIM;
          end
        end
      end
      VICTIM: begin
        way_n   = (&vvec_q) ? victim_c[idx_q] : first_invalid(vvec_q);
        state_n = (vvec_q[way_n] && dvec_q[way_n]) ? WB : FILL;
      end
      WB:      if (wb_ack)   state_n = FILL;
      FILL:    if (fill_ack) state_n = UPDATE;
      UPDATE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx_q     <= '0;
      hit_q     <= 1'b0;
      vvec_q    <= '0;
      dvec_q    <= '0;
      way_q     <= '0;
      req_ready <= 1'b1;
      wb_req    <= 1'b0;
      wb_way    <= '0;
      fill_req  <= 1'b0;
      fill_way  <= '0;
      done      <= 1'b0;
      done_way  <= '0;
      done_miss <= 1'b0;
    end else begin
      state     <= state_n;
      idx_q     <= idx_n;
      hit_q     <= hit_n;
      vvec_q    <= vvec_n;
      dvec_q    <= dvec_n;
      way_q     <= way_n;
      req_ready <= (state_n == IDLE);
      wb_req    <= (state_n == WB);
      wb_way    <= (state_n == WB) ? way_n : '0;
      fill_req  <= (state_n == FILL);
      fill_way  <= (state_n == FILL) ? way_n : '0;
      done      <= (state_n == UPDATE);
      done_way  <= (state_n == UPDATE) ? way_n : '0;
      done_miss <= (state_n == UPDATE) && !hit_n;
    end
  end

endmodule

// File: tb/tb_way_alloc_ctrl.sv
// Directed, table-driven bench for way_alloc_ctrl with hand-computed PLRU victims.
module tb_way_alloc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_index;
  logic       req_hit;
  logic [2:0] req_hit_way;
  logic [7:0] req_valid_vec;
  logic [7:0] req_dirty_vec;
  logic       wb_req;
  logic [2:0] wb_way;
  logic       wb_ack;
  logic       fill_req;
  logic [2:0] fill_way;
  logic       fill_ack;
  logic       done;
  logic [2:0] done_way;
  logic       done_miss;

  int errors = 0;
  int checks = 0;

  way_alloc_ctrl #(.S_INDEX(3), .NUM_WAYS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_index     (req_index),
    .req_hit       (req_hit),
    .req_hit_way   (req_hit_way),
    .req_valid_vec (req_valid_vec),
    .req_dirty_vec (req_dirty_vec),
    .wb_req        (wb_req),
    .wb_way        (wb_way),
    .wb_ack        (wb_ack),
    .fill_req      (fill_req),
    .fill_way      (fill_way),
    .fill_ack      (fill_ack),
    .done          (done),
    .done_way      (done_way),
    .done_miss     (done_miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] idx;
    logic       hit;
    logic [2:0] hway;
    logic [7:0] vv;
    logic [7:0] dv;
    logic       exp_wb;
    logic [2:0] exp_way;
    int         exp_lat;
  } vec_t;

  vec_t tbl [8];
  vec_t v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request with immediate acks; inputs are scrambled after the handshake
  task automatic run_req(input vec_t r, input string tag);
    int         cyc;
    logic       got, saw_wb, both;
    logic [2:0] wbw, flw;
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid     = 1'b1;
    req_index     = r.idx;
    req_hit       = r.hit;
    req_hit_way   = r.hway;
    req_valid_vec = r.vv;
    req_dirty_vec = r.dv;
    step();
    req_valid     = 1'b0;
    req_index     = ~r.idx;
    req_hit       = ~r.hit;
    req_hit_way   = ~r.hway;
    req_valid_vec = 8'h00;
    req_dirty_vec = 8'hFF;
    chk({tag, " busy"}, 32'(req_ready), 32'd0);
    cyc = 1; got = 1'b0; saw_wb = 1'b0; both = 1'b0; wbw = '0; flw = '0;
    while (cyc < 40 && !got) begin
      if (done) begin
        got = 1'b1;
      end else begin
        if (wb_req && fill_req) both = 1'b1;
        if (wb_req) begin saw_wb = 1'b1; wbw = wb_way; end
        if (fill_req) flw = fill_way;
        wb_ack   = wb_req;
        fill_ack = fill_req;
        step();
        cyc++;
      end
    end
    wb_ack   = 1'b0;
    fill_ack = 1'b0;
    chk({tag, " done_seen"}, 32'(got), 32'd1);
    chk({tag, " done_way"}, 32'(done_way), 32'(r.exp_way));
    chk({tag, " done_miss"}, 32'(done_miss), 32'(!r.hit));
    chk({tag, " latency"}, 32'(cyc), 32'(r.exp_lat));
    chk({tag, " wb_seen"}, 32'(saw_wb), 32'(r.exp_wb));
    chk({tag, " wb_fill_overlap"}, 32'(both), 32'd0);
    if (r.exp_wb) chk({tag, " wb_way"}, 32'(wbw), 32'(r.exp_way));
    if (!r.hit)   chk({tag, " fill_way"}, 32'(flw), 32'(r.exp_way));
    step();
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
    chk({tag, " ready_again"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    // idx hit hway vv dv exp_wb exp_way lat
    tbl[0] = '{3'd2, 1'b0, 3'd0, 8'hFF, 8'h00, 1'b0, 3'd0, 3};
    tbl[1] = '{3'd2, 1'b0, 3'd0, 8'hFF, 8'h00, 1'b0, 3'd4, 3};
    tbl[2] = '{3'd3, 1'b0, 3'd0, 8'hFF, 8'h00, 1'b0, 3'd0, 3};
    tbl[3] = '{3'd1, 1'b0, 3'd0, 8'hE7, 8'hFF, 1'b0, 3'd3, 3};
    tbl[4] = '{3'd0, 1'b1, 3'd6, 8'hFF, 8'h00, 1'b0, 3'd6, 1};
    tbl[5] = '{3'd0, 1'b0, 3'd0, 8'hFF, 8'h00, 1'b0, 3'd0, 3};
    tbl[6] = '{3'd5, 1'b0, 3'd0, 8'hFF, 8'h01, 1'b1, 3'd0, 4};
    tbl[7] = '{3'd2, 1'b0, 3'd0, 8'hFF, 8'h04, 1'b1, 3'd2, 4};

    rst = 1'b1; req_valid = 1'b0; req_index = '0; req_hit = 1'b0; req_hit_way = '0;
    req_valid_vec = '0; req_dirty_vec = '0; wb_ack = 1'b0; fill_ack = 1'b0;
    step();
    step();
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset wb_req", 32'(wb_req), 32'd0);
    chk("reset fill_req", 32'(fill_req), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_req(tbl[i], $sformatf("vec%0d", i));

    // Dirty miss on untouched set 6 with a delayed writeback ack
    req_valid = 1'b1; req_index = 3'd6; req_hit = 1'b0;
    req_valid_vec = 8'hFF; req_dirty_vec = 8'h01;
    step();
    req_valid = 1'b0;
    chk("hold victim no wb", 32'(wb_req), 32'd0);
    step();
    chk("hold wb_req", 32'(wb_req), 32'd1);
    chk("hold wb_way", 32'(wb_way), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("hold wb_req c%0d", i), 32'(wb_req), 32'd1);
      chk($sformatf("hold no fill c%0d", i), 32'(fill_req), 32'd0);
    end
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    chk("hold wb dropped", 32'(wb_req), 32'd0);
    chk("hold fill_req", 32'(fill_req), 32'd1);
    chk("hold fill_way", 32'(fill_way), 32'd0);
    step();
    chk("hold fill waits", 32'(fill_req), 32'd1);
    chk("hold no early done", 32'(done), 32'd0);
    fill_ack = 1'b1;
    step();
    fill_ack = 1'b0;
    chk("hold done", 32'(done), 32'd1);
    chk("hold done_way", 32'(done_way), 32'd0);
    chk("hold done_miss", 32'(done_miss), 32'd1);
    chk("hold fill dropped", 32'(fill_req), 32'd0);
    step();
    chk("hold done pulse", 32'(done), 32'd0);

    // Stray acks while idle
    wb_ack = 1'b1; fill_ack = 1'b1;
    step();
    step();
    wb_ack = 1'b0; fill_ack = 1'b0;
    chk("idle ack ready", 32'(req_ready), 32'd1);
    chk("idle ack wb_req", 32'(wb_req), 32'd0);
    chk("idle ack fill_req", 32'(fill_req), 32'd0);
    chk("idle ack done", 32'(done), 32'd0);

    // Reset while in WB abandons the request and clears every tree
    req_valid = 1'b1; req_index = 3'd2; req_hit = 1'b0;
    req_valid_vec = 8'hFF; req_dirty_vec = 8'hFF;
    step();
    req_valid = 1'b0;
    step();
    chk("rstwb in wb", 32'(wb_req), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstwb ready", 32'(req_ready), 32'd1);
    chk("rstwb wb_req", 32'(wb_req), 32'd0);
    chk("rstwb done", 32'(done), 32'd0);
    step();
    chk("rstwb no done later", 32'(done), 32'd0);
    chk("rstwb fill_req", 32'(fill_req), 32'd0);
    for (int i = 0; i < 8; i++) begin
      v = '{3'(i), 1'b0, 3'd0, 8'hFF, 8'h00, 1'b0, 3'd0, 3};
      run_req(v, $sformatf("post_rst_set%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
